// File: rtl/if_id_pipe_buf.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no live entry, out_valid=0, in_ready=1
// ST_FULL  | main entry live, drives decode, in_ready=1
// ST_SKID  | main + skid live, in_ready=0 until decode consumes
module if_id_pipe_buf #(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       PC_W      = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] main_instr;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] skid_instr;
  logic [PC_W-1:0]   skid_pc;

  logic accept;
  logic consume;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clear_main;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_FULL;
        ST_FULL: begin
          if (accept && !consume)      state_nxt = ST_SKID;
          else if (!accept && consume) state_nxt = ST_EMPTY;
        end
        ST_SKID:  if (consume) state_nxt = ST_FULL;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so in_ready never
  // depends combinationally on out_ready.
  always_comb begin
    in_ready       = 1'b1;
    out_valid      = 1'b0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    case (state)
      ST_EMPTY: begin
        load_main_in = accept;
      end
      ST_FULL: begin
        out_valid    = 1'b1;
        load_main_in = accept & consume;
        load_skid    = accept & ~consume;
        clear_main   = ~accept & consume;
      end
      ST_SKID: begin
        in_ready       = 1'b0;
        out_valid      = 1'b1;
        load_main_skid = consume;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  // Main entry is reset to NOP/0 whenever it is not live, so outputs need no mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_instr <= NOP_VALUE;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_instr <= NOP_VALUE;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (load_main_in) begin
        main_instr <= in_instr;
        main_pc    <= in_pc;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
      end else if (clear_main) begin
        main_instr <= NOP_VALUE;
        main_pc    <= '0;
      end
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
      end
    end
  end

  assign out_instr = main_instr;
  assign out_pc    = main_pc;

  // Saturating stall counter; flush cycles still count if decode is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
